// File: rtl/addr_region_pkg.sv
// rtl/addr_region_pkg.sv - shared types and reset table for address region decoders
package addr_region_pkg;

    // Widest address any decoder built on this table may use.
    localparam int REGION_MAX_W = 32;

    typedef struct packed {
        logic [REGION_MAX_W-1:0] value;
        logic [REGION_MAX_W-1:0] care;
    } region_cfg_t;

    // 101z and 001z; upper bits of wider addresses are don't-care for these two.
    localparam region_cfg_t REGION0_RST = '{value: 32'h0000_000A, care: 32'h0000_000E};
    localparam region_cfg_t REGION1_RST = '{value: 32'h0000_0002, care: 32'h0000_000E};
    // Remaining entries only match the all-zero address.
    localparam region_cfg_t REGION_DEFAULT_RST = '{value: 32'h0000_0000, care: 32'hFFFF_FFFF};

    function automatic region_cfg_t rst_entry(input int idx);
        case (idx)
            0:       return REGION0_RST;
            1:       return REGION1_RST;
            default: return REGION_DEFAULT_RST;
        endcase
    endfunction

endpackage

// File: rtl/addr_region_match.sv
// rtl/addr_region_match.sv - combinational wildcard match, lowest index wins
module addr_region_match #(
    parameter int ADDR_W      = 4,
    parameter int NUM_REGIONS = 2,
    parameter int IDX_W       = 1
) (
    input  logic [ADDR_W-1:0]                   addr,
    input  logic [NUM_REGIONS-1:0][ADDR_W-1:0]  value,
    input  logic [NUM_REGIONS-1:0][ADDR_W-1:0]  care,
    output logic                                hit,
    output logic [IDX_W-1:0]                    idx
);

    // Scan from the top down so the lowest matching entry is the last one written.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
            if (((addr ^ value[i]) & care[i]) == '0) begin
                hit = 1'b1;
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/addr_region_decoder.sv
// rtl/addr_region_decoder.sv - registered address region decoder with hit/miss statistics
module addr_region_decoder
    import addr_region_pkg::*;
#(
    parameter int ADDR_W      = 4,
    parameter int NUM_REGIONS = 2,
    parameter int CNT_W       = 8,
    localparam int IDX_W      = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic              cfg_we,
    input  logic [IDX_W-1:0]  cfg_idx,
    input  logic [ADDR_W-1:0] cfg_value,
    input  logic [ADDR_W-1:0] cfg_care,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_hit,
    output logic [IDX_W-1:0]  out_region,
    output logic [CNT_W-1:0]  hit_cnt,
    output logic [CNT_W-1:0]  miss_cnt
);

    logic [NUM_REGIONS-1:0][ADDR_W-1:0] value_q;
    logic [NUM_REGIONS-1:0][ADDR_W-1:0] care_q;
    logic [NUM_REGIONS-1:0][ADDR_W-1:0] rst_value;
    logic [NUM_REGIONS-1:0][ADDR_W-1:0] rst_care;
    logic                               match_hit;
    logic [IDX_W-1:0]                   match_idx;
    logic                               accept;
    logic                               drain;
    logic                               cfg_ok;
    region_cfg_t                        rst_e;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign drain    = out_valid && out_ready;
    assign cfg_ok   = cfg_we && (32'(cfg_idx) < NUM_REGIONS);

    // Reset table contents, narrowed to this decoder's address width.
    always_comb begin
        rst_e     = '0;
        rst_value = '0;
        rst_care  = '0;
        for (int i = 0; i < NUM_REGIONS; i++) begin
            rst_e        = rst_entry(i);
            rst_value[i] = ADDR_W'(rst_e.value);
            rst_care[i]  = ADDR_W'(rst_e.care);
        end
    end

    // Decode against the table as it stands before any same-cycle write.
    addr_region_match #(
        .ADDR_W      (ADDR_W),
        .NUM_REGIONS (NUM_REGIONS),
        .IDX_W       (IDX_W)
    ) u_match (
        .addr  (in_addr),
        .value (value_q),
        .care  (care_q),
        .hit   (match_hit),
        .idx   (match_idx)
    );

    // Region table: restored on reset, out-of-range writes dropped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            value_q <= rst_value;
            care_q  <= rst_care;
        end else if (cfg_ok) begin
            value_q[cfg_idx] <= cfg_value;
            care_q[cfg_idx]  <= cfg_care;
        end
    end

    // Single-stage output register; reloads on accept, empties on a bare drain.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_addr   <= '0;
            out_hit    <= 1'b0;
            out_region <= '0;
        end else if (accept) begin
            out_valid  <= 1'b1;
            out_addr   <= in_addr;
            out_hit    <= match_hit;
            out_region <= match_idx;
        end else if (drain) begin
            out_valid  <= 1'b0;
        end
    end

    // Saturating statistics, counted at the output handshake.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (drain) begin
            if (out_hit) begin
                if (hit_cnt != {CNT_W{1'b1}}) begin
                    hit_cnt <= hit_cnt + 1'b1;
                end
            end else begin
                if (miss_cnt != {CNT_W{1'b1}}) begin
                    miss_cnt <= miss_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_addr_region_decoder.sv
// tb/tb_addr_region_decoder.sv - randomized model-checked bench for addr_region_decoder
module tb_addr_region_decoder;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] in_addr;
    logic       out_ready;
    logic       cfg_we;
    logic [1:0] cfg_idx;
    logic [3:0] cfg_value;
    logic [3:0] cfg_care;

    logic       in_ready0, out_valid0, out_hit0;
    logic [3:0] out_addr0;
    logic [1:0] out_region0;
    logic [7:0] hit_cnt0, miss_cnt0;

    logic       in_ready1, out_valid1, out_hit1;
    logic [3:0] out_addr1;
    logic [0:0] out_region1;
    logic [1:0] hit_cnt1, miss_cnt1;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: [0] is the 3-region/8-bit decoder, [1] the 2-region/2-bit one.
    bit         m_known;
    bit         m_valid [2];
    logic [3:0] m_addr  [2];
    bit         m_hit   [2];
    int         m_region[2];
    int         m_hc    [2];
    int         m_mc    [2];
    logic [3:0] tval    [2][3];
    logic [3:0] tcare   [2][3];
    int         nreg    [2] = '{3, 2};
    int         cmax    [2] = '{255, 3};

    addr_region_decoder #(.ADDR_W(4), .NUM_REGIONS(3), .CNT_W(8)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
        .in_addr(in_addr), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
        .cfg_value(cfg_value), .cfg_care(cfg_care), .out_valid(out_valid0),
        .out_ready(out_ready), .out_addr(out_addr0), .out_hit(out_hit0),
        .out_region(out_region0), .hit_cnt(hit_cnt0), .miss_cnt(miss_cnt0)
    );

    addr_region_decoder #(.ADDR_W(4), .NUM_REGIONS(2), .CNT_W(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
        .in_addr(in_addr), .cfg_we(1'b0), .cfg_idx(1'b0),
        .cfg_value(4'h0), .cfg_care(4'h0), .out_valid(out_valid1),
        .out_ready(out_ready), .out_addr(out_addr1), .out_hit(out_hit1),
        .out_region(out_region1), .hit_cnt(hit_cnt1), .miss_cnt(miss_cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic void model_reset(input int k);
        m_valid[k]  = 0;
        m_addr[k]   = 4'h0;
        m_hit[k]    = 0;
        m_region[k] = 0;
        m_hc[k]     = 0;
        m_mc[k]     = 0;
        tval[k][0] = 4'b1010; tcare[k][0] = 4'b1110;
        tval[k][1] = 4'b0010; tcare[k][1] = 4'b1110;
        tval[k][2] = 4'b0000; tcare[k][2] = 4'b1111;
    endfunction

    // First table entry whose cared-about bits equal the address.
    function automatic void ref_decode(input int k, input logic [3:0] a,
                                       output bit hit, output int region);
        hit = 0;
        region = 0;
        for (int i = 0; i < nreg[k]; i++) begin
            bit ok;
            ok = 1;
            for (int b = 0; b < 4; b++)
                if (tcare[k][i][b] && (a[b] != tval[k][i][b])) ok = 0;
            if (ok) begin
                hit = 1;
                region = i;
                return;
            end
        end
    endfunction

    task automatic step(input bit r, input bit v, input logic [3:0] a, input bit ord,
                        input bit we, input logic [1:0] idx,
                        input logic [3:0] val, input logic [3:0] care);
        rst_n = r; in_valid = v; in_addr = a; out_ready = ord;
        cfg_we = we; cfg_idx = idx; cfg_value = val; cfg_care = care;
        #1;
        if (m_known) begin
            check("in_ready0", in_ready0, (!m_valid[0] || ord) ? 1 : 0);
            check("in_ready1", in_ready1, (!m_valid[1] || ord) ? 1 : 0);
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            if (!r) begin
                model_reset(k);
            end else begin
                bit rdy, acc, drn, h;
                int rg;
                rdy = !m_valid[k] || ord;
                acc = v && rdy;
                drn = m_valid[k] && ord;
                if (drn) begin
                    if (m_hit[k]) m_hc[k] = (m_hc[k] < cmax[k]) ? m_hc[k] + 1 : cmax[k];
                    else          m_mc[k] = (m_mc[k] < cmax[k]) ? m_mc[k] + 1 : cmax[k];
                end
                if (acc) begin
                    ref_decode(k, a, h, rg);
                    m_valid[k] = 1; m_addr[k] = a; m_hit[k] = h; m_region[k] = rg;
                end else if (drn) begin
                    m_valid[k] = 0;
                end
                if (k == 0 && we && int'(idx) < nreg[0]) begin
                    tval[0][idx] = val;
                    tcare[0][idx] = care;
                end
            end
        end
        if (!r) m_known = 1;
        if (m_known) begin
            check("out_valid0",  out_valid0,  m_valid[0]);
            check("out_addr0",   out_addr0,   m_addr[0]);
            check("out_hit0",    out_hit0,    m_hit[0]);
            check("out_region0", out_region0, m_region[0]);
            check("hit_cnt0",    hit_cnt0,    m_hc[0]);
            check("miss_cnt0",   miss_cnt0,   m_mc[0]);
            check("out_valid1",  out_valid1,  m_valid[1]);
            check("out_addr1",   out_addr1,   m_addr[1]);
            check("out_hit1",    out_hit1,    m_hit[1]);
            check("out_region1", out_region1, m_region[1]);
            check("hit_cnt1",    hit_cnt1,    m_hc[1]);
            check("miss_cnt1",   miss_cnt1,   m_mc[1]);
        end
    endtask

    task automatic send(input logic [3:0] a, input bit ord);
        step(1, 1, a, ord, 0, 2'd0, 4'h0, 4'h0);
    endtask

    task automatic idle(input bit ord);
        step(1, 0, 4'h0, ord, 0, 2'd0, 4'h0, 4'h0);
    endtask

    initial begin
        m_known = 0;
        model_reset(0);
        model_reset(1);
        rst_n = 0; in_valid = 0; in_addr = 0; out_ready = 0;
        cfg_we = 0; cfg_idx = 0; cfg_value = 0; cfg_care = 0;

        step(0, 0, 4'h0, 0, 0, 2'd0, 4'h0, 4'h0);
        step(0, 0, 4'h0, 0, 0, 2'd0, 4'h0, 4'h0);

        // Reset table hits, then a miss.
        send(4'b1011, 1);
        check("t1_region0", out_region0, 0);
        send(4'b0011, 1);
        check("t1_region1", out_region0, 1);
        send(4'b1111, 1);
        check("t2_hit", out_hit0, 0);
        idle(1);
        check("t1_hit_cnt", hit_cnt0, 2);
        check("t2_miss_cnt", miss_cnt0, 1);

        // Stall with valid held, then release into back-to-back traffic.
        for (int i = 0; i < 6; i++) send(4'b0101, 0);
        check("t3_stall_ready", in_ready0, 0);
        check("t3_stall_addr", out_addr0, 5);
        for (int i = 0; i < 6; i++) send(4'(i + 8), 1);
        idle(1);

        // Write racing an accept: old table decodes, new entry applies next.
        step(1, 1, 4'b0011, 1, 1, 2'd0, 4'b0000, 4'b0000);
        check("t4_old_entry", out_region0, 1);
        send(4'b0011, 1);
        check("t4_new_entry", out_region0, 0);
        // Out-of-range index must leave the table alone.
        step(1, 0, 4'h0, 1, 1, 2'd3, 4'hF, 4'hF);
        send(4'b0000, 1);
        check("t4_ignored_idx", out_region0, 0);

        // Reset while stalled with a result held.
        send(4'b1010, 0);
        send(4'b1011, 0);
        step(0, 1, 4'b1011, 0, 0, 2'd0, 4'h0, 4'h0);
        check("t6_valid", out_valid0, 0);
        check("t6_hit_cnt", hit_cnt0, 0);
        send(4'b0000, 1);
        check("t6_table_region", out_region0, 2);
        send(4'b1010, 1);
        check("t6_region0", out_region0, 0);

        // Miss saturation on the 2-bit counter.
        step(0, 0, 4'h0, 1, 0, 2'd0, 4'h0, 4'h0);
        for (int i = 0; i < 5; i++) send(4'b1111, 1);
        idle(1);
        check("t5_sat", miss_cnt1, 3);
        send(4'b1111, 1);
        idle(1);
        check("t5_hold", miss_cnt1, 3);

        // Random traffic, backpressure, config writes and occasional resets.
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 59) != 0),
                 ($urandom_range(0, 3) != 0),
                 4'($urandom_range(0, 15)),
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 7) == 0),
                 2'($urandom_range(0, 3)),
                 4'($urandom_range(0, 15)),
                 4'($urandom_range(0, 15)));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/addr_region_decoder.md
# addr_region_decoder

Registered, flow-controlled address region decoder that accepts a stream of addresses and tags each one with the first matching wildcard region. It is the stage directly downstream of the address source. It replaces ad-hoc `casez` matching with a programmable value/care-mask table. It also keeps saturating hit and miss statistics for debug readout.

## Interface
Parameters:
- `ADDR_W`, 4: address width.
- `NUM_REGIONS`, 2: number of table entries, ≥1.
- `CNT_W`, 8: width of the statistics counters.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `in_valid`  in  1  upstream address valid.
- `in_ready`  out  1  block can accept an address this cycle.
- `in_addr`  in  ADDR_W  address to decode.
- `cfg_we`  in  1  table write strobe.
- `cfg_idx`  in  $clog2(NUM_REGIONS) (min 1)  entry to write.
- `cfg_value`  in  ADDR_W  match value.
- `cfg_care`  in  ADDR_W  care mask (1 = compare bit, 0 = don't care).
- `out_valid`  out  1  decoded result valid.
- `out_ready`  in  1  downstream accepts the result.
- `out_addr`  out  ADDR_W  the address that was decoded.
- `out_hit`  out  1  at least one region matched.
- `out_region`  out  $clog2(NUM_REGIONS) (min 1)  index of the winning region; 0 when there is no hit.
- `hit_cnt`, `miss_cnt`  out  CNT_W  saturating statistics counters.

## Operation
- Match rule for region i: `((in_addr ^ value[i]) & care[i]) == 0`.
- Priority: the lowest matching index wins.
- Table reset contents:
  - entry 0 = value 4'b1010, care 4'b1110 (equivalent to 101z);
  - entry 1 = value 4'b0010, care 4'b1110 (equivalent to 001z);
  - entries ≥2 = value 0, care all-ones.
- Output register is a single stage with valid/ready.
  - `in_ready = !out_valid || out_ready`.
  - Accept when `in_valid && in_ready`; on accept, load `out_addr`, `out_hit` and `out_region` and set `out_valid`.
  - `out_valid` clears on `out_valid && out_ready` when no new address is accepted the same cycle.
  - Accept and drain in the same cycle: the register reloads and `out_valid` stays 1. Full throughput is one address per cycle.
- Output is held stable while `out_valid && !out_ready`.
- Statistics:
  - On each output handshake (`out_valid && out_ready`), `hit_cnt` increments if `out_hit`, otherwise `miss_cnt` increments.
  - Both counters saturate at 2^CNT_W−1 and never wrap.
- Config writes:
  - `cfg_we` writes entry `cfg_idx` at the clock edge.
  - An address accepted in the same cycle as a write is decoded with the old entry. The new entry applies from the next cycle.
  - `cfg_idx ≥ NUM_REGIONS` is ignored.
- Reset (`rst_n` = 0 at an edge):
  - `out_valid`=0, `out_addr`=0, `out_hit`=0, `out_region`=0, `hit_cnt`=0, `miss_cnt`=0, table restored to the reset contents.
  - Any in-flight result is discarded and not counted.
  - `in_ready` is 1 in the first cycle after reset release.

## Timing
- Latency is 1 cycle: an address accepted at edge N is presented on `out_*` immediately after edge N.
- `in_ready` depends combinationally on `out_ready`; there is no other combinational path from input to output.
- Counters update at the edge that completes the output handshake and are visible the following cycle.
- Match logic fits one cycle at ADDR_W ≤ 32 and NUM_REGIONS ≤ 16.

## Structure
- Package `addr_region_pkg` holds:
  - `region_cfg_t` struct {value, care};
  - reset-table constants `REGION0_RST` and `REGION1_RST`;
  - a default-entry constant.
- Sub-module `addr_region_match` is purely combinational. It takes the address and table and produces hit and index with lowest-index priority. It is instantiated once and is reusable by other decoders.
- The top level contains the table registers, the output pipeline register, handshake logic and counters.

## Test plan
1. Reset table, send 4'b1011 then 4'b0011 with `out_ready`=1 -> hit/region 0, then hit/region 1; `hit_cnt`=2.
2. Send 4'b1111 -> `out_hit`=0, `out_region`=0; `miss_cnt`=1, `hit_cnt` unchanged.
3. Stall: hold `out_ready`=0 for 5 cycles with `in_valid`=1 -> `in_ready`=0, outputs stable, counters frozen. Release -> back-to-back addresses accepted, one result per cycle, none lost or duplicated.
4. Write entry 0 with value 4'b0000, care 4'b0000 in the same cycle 4'b0011 is accepted -> that address decodes to region 1. The next address, 4'b0011, decodes to region 0 (catch-all, lower index).
5. CNT_W=2, send 5 misses -> `miss_cnt` reads 3 and stays at 3.
6. Assert `rst_n`=0 while `out_valid`=1 and stalled -> next cycle `out_valid`=0, counters 0, table back to reset, 4'b1010 hits region 0.
